// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared encodings for the ID-stage forwarding and hazard control slice.
package fwd_hazard_ctrl_pkg;

    // Register-number width of the datapath.
    localparam int REG_AW = 5;

    // Write-back source encodings carried with each pipeline entry.
    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MEM = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    // Forward-mux select encodings consumed by the datapath.
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/fwd_hazard_ctrl_select.sv
// Per-operand forward select and load/link hazard detection.
module fwd_select
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int AW = REG_AW
) (
    input  logic [AW-1:0] src,
    input  logic          use_src,
    input  logic          ex_valid,
    input  logic [AW-1:0] ex_rd,
    input  logic [1:0]    ex_m2r,
    input  logic          mem_valid,
    input  logic [AW-1:0] mem_rd,
    output logic [1:0]    sel,
    output logic          hazard
);

    logic src_nz;
    logic ex_hit;
    logic mem_hit;

    // Register $0 never matches, even if a stale rd of 0 were marked valid.
    assign src_nz  = (src != '0);
    assign ex_hit  = use_src && src_nz && ex_valid  && (ex_rd  == src);
    assign mem_hit = use_src && src_nz && mem_valid && (mem_rd == src);

    // EX (youngest) wins; an EX load/link result is not ready yet, so it
    // raises a hazard instead of selecting EX.
    always_comb begin
        sel    = FWD_REG;
        hazard = 1'b0;
        if (ex_hit && (ex_m2r == M2R_ALU)) begin
            sel = FWD_EX;
        end else if (mem_hit) begin
            sel = FWD_MEM;
        end
        if (ex_hit && (ex_m2r != M2R_ALU)) begin
            hazard = 1'b1;
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding selects, write-back source and stall/bubble control for ID.
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = fwd_hazard_ctrl_pkg::REG_AW,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Hold,
    input  logic              Branch_Flush,
    input  logic [REG_AW-1:0] ID_rs,
    input  logic [REG_AW-1:0] ID_rt,
    input  logic              ID_uses_rs,
    input  logic              ID_uses_rt,
    input  logic              ID_RegWrite,
    input  logic [REG_AW-1:0] ID_Write_reg,
    input  logic [1:0]        ID_MemtoReg,
    output logic [1:0]        ForwardA,
    output logic [1:0]        ForwardB,
    output logic [1:0]        MEM_MemtoReg,
    output logic              Stall,
    output logic              Bubble,
    output logic [CNT_W-1:0]  Stall_count
);

    // Shadow copy of the EX and MEM destination fields.
    logic              ex_valid;
    logic [REG_AW-1:0] ex_rd;
    logic [1:0]        ex_m2r;
    logic              mem_valid;
    logic [REG_AW-1:0] mem_rd;
    logic [1:0]        mem_m2r;

    logic hazard_a;
    logic hazard_b;
    logic hazard;
    logic pipe_stall;

    fwd_select #(.AW(REG_AW)) u_sel_a (
        .src       (ID_rs),
        .use_src   (ID_uses_rs),
        .ex_valid  (ex_valid),
        .ex_rd     (ex_rd),
        .ex_m2r    (ex_m2r),
        .mem_valid (mem_valid),
        .mem_rd    (mem_rd),
        .sel       (ForwardA),
        .hazard    (hazard_a)
    );

    fwd_select #(.AW(REG_AW)) u_sel_b (
        .src       (ID_rt),
        .use_src   (ID_uses_rt),
        .ex_valid  (ex_valid),
        .ex_rd     (ex_rd),
        .ex_m2r    (ex_m2r),
        .mem_valid (mem_valid),
        .mem_rd    (mem_rd),
        .sel       (ForwardB),
        .hazard    (hazard_b)
    );

    assign hazard = hazard_a | hazard_b;

    // A squashed ID instruction never stalls; Hold freezes the front end regardless.
    always_comb begin
        pipe_stall   = hazard && !Branch_Flush;
        Stall        = pipe_stall || Hold;
        Bubble       = hazard || Branch_Flush;
        MEM_MemtoReg = mem_valid ? mem_m2r : M2R_ALU;
    end

    // Advance the shadow pipeline and the stall counter; Hold freezes everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            ex_rd       <= '0;
            ex_m2r      <= M2R_ALU;
            mem_valid   <= 1'b0;
            mem_rd      <= '0;
            mem_m2r     <= M2R_ALU;
            Stall_count <= '0;
        end else if (!Hold) begin
            mem_valid <= ex_valid;
            mem_rd    <= ex_rd;
            mem_m2r   <= ex_m2r;
            if (Bubble) begin
                ex_valid <= 1'b0;
                ex_rd    <= '0;
                ex_m2r   <= M2R_ALU;
            end else begin
                ex_valid <= ID_RegWrite && (ID_Write_reg != '0);
                ex_rd    <= ID_Write_reg;
                ex_m2r   <= ID_MemtoReg;
            end
            if (pipe_stall && (Stall_count != '1)) begin
                Stall_count <= Stall_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed self-checking bench for fwd_hazard_ctrl.
module tb_fwd_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic        Hold;
    logic        Branch_Flush;
    logic [4:0]  ID_rs;
    logic [4:0]  ID_rt;
    logic        ID_uses_rs;
    logic        ID_uses_rt;
    logic        ID_RegWrite;
    logic [4:0]  ID_Write_reg;
    logic [1:0]  ID_MemtoReg;
    logic [1:0]  ForwardA;
    logic [1:0]  ForwardB;
    logic [1:0]  MEM_MemtoReg;
    logic        Stall;
    logic        Bubble;
    logic [15:0] Stall_count;

    int checks;
    int errors;

    fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .Hold         (Hold),
        .Branch_Flush (Branch_Flush),
        .ID_rs        (ID_rs),
        .ID_rt        (ID_rt),
        .ID_uses_rs   (ID_uses_rs),
        .ID_uses_rt   (ID_uses_rt),
        .ID_RegWrite  (ID_RegWrite),
        .ID_Write_reg (ID_Write_reg),
        .ID_MemtoReg  (ID_MemtoReg),
        .ForwardA     (ForwardA),
        .ForwardB     (ForwardB),
        .MEM_MemtoReg (MEM_MemtoReg),
        .Stall        (Stall),
        .Bubble       (Bubble),
        .Stall_count  (Stall_count)
    );

    // Clock: 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge; inputs change 1 unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #2;
    endtask

    // Present an ID instruction.
    task automatic drive_id(input logic [4:0] rs, input logic urs,
                            input logic [4:0] rt, input logic urt,
                            input logic rw, input logic [4:0] wr,
                            input logic [1:0] m2r);
        ID_rs        = rs;
        ID_uses_rs   = urs;
        ID_rt        = rt;
        ID_uses_rt   = urt;
        ID_RegWrite  = rw;
        ID_Write_reg = wr;
        ID_MemtoReg  = m2r;
    endtask

    task automatic drive_nop();
        drive_id(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 2'b00);
    endtask

    task automatic test_reset();
        reset = 1'b1; Hold = 1'b0; Branch_Flush = 1'b0;
        drive_nop();
        tick(); tick();
        reset = 1'b0;
        settle();
        checks++; if (ForwardA !== 2'b00) begin errors++; $display("FAIL reset_fwd_a: got %b want 00", ForwardA); end
        checks++; if (ForwardB !== 2'b00) begin errors++; $display("FAIL reset_fwd_b: got %b want 00", ForwardB); end
        checks++; if (MEM_MemtoReg !== 2'b00) begin errors++; $display("FAIL reset_m2r: got %b want 00", MEM_MemtoReg); end
        checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", Stall); end
        checks++; if (Bubble !== 1'b0) begin errors++; $display("FAIL reset_bubble: got %b want 0", Bubble); end
        checks++; if (Stall_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", Stall_count); end
        Branch_Flush = 1'b1;
        settle();
        checks++; if (Bubble !== 1'b1) begin errors++; $display("FAIL reset_flush_bubble: got %b want 1", Bubble); end
        Branch_Flush = 1'b0;
    endtask

    task automatic test_alu_back_to_back();
        tick();
        drive_id(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 2'b00);   // add r3
        tick();
        drive_id(5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 2'b00);   // reads rs=r3
        settle();
        checks++; if (ForwardA !== 2'b01) begin errors++; $display("FAIL alu_fwd_a_ex: got %b want 01", ForwardA); end
        checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL alu_stall: got %b want 0", Stall); end
        checks++; if (Bubble !== 1'b0) begin errors++; $display("FAIL alu_bubble: got %b want 0", Bubble); end
        tick();
        drive_id(5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 2'b00);   // reads rt=r3
        settle();
        checks++; if (ForwardB !== 2'b10) begin errors++; $display("FAIL alu_fwd_b_mem: got %b want 10", ForwardB); end
        checks++; if (ForwardA !== 2'b00) begin errors++; $display("FAIL alu_fwd_a_idle: got %b want 00", ForwardA); end
        checks++; if (MEM_MemtoReg !== 2'b00) begin errors++; $display("FAIL alu_mem_m2r: got %b want 00", MEM_MemtoReg); end
    endtask

    task automatic test_load_use();
        tick(); drive_nop();
        tick();
        drive_id(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 2'b01);   // lw r5
        tick();
        drive_id(5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 2'b00);   // reads rt=r5
        settle();
        checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL load_use_stall: got %b want 1", Stall); end
        checks++; if (Bubble !== 1'b1) begin errors++; $display("FAIL load_use_bubble: got %b want 1", Bubble); end
        tick();                                                 // same instruction held in ID
        settle();
        checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL load_use_one_cycle: got %b want 0", Stall); end
        checks++; if (Bubble !== 1'b0) begin errors++; $display("FAIL load_use_bubble_clr: got %b want 0", Bubble); end
        checks++; if (ForwardB !== 2'b10) begin errors++; $display("FAIL load_use_fwd_b: got %b want 10", ForwardB); end
        checks++; if (MEM_MemtoReg !== 2'b01) begin errors++; $display("FAIL load_use_m2r: got %b want 01", MEM_MemtoReg); end
        checks++; if (Stall_count !== 16'd1) begin errors++; $display("FAIL load_use_count: got %0d want 1", Stall_count); end
    endtask

    task automatic test_link();
        tick();
        drive_id(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd31, 2'b10);  // jal r31
        tick();
        drive_id(5'd31, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 2'b00);  // reads rs=r31
        settle();
        checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL link_stall: got %b want 1", Stall); end
        tick();
        settle();
        checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL link_one_cycle: got %b want 0", Stall); end
        checks++; if (ForwardA !== 2'b10) begin errors++; $display("FAIL link_fwd_a: got %b want 10", ForwardA); end
        checks++; if (MEM_MemtoReg !== 2'b10) begin errors++; $display("FAIL link_m2r: got %b want 10", MEM_MemtoReg); end
        checks++; if (Stall_count !== 16'd2) begin errors++; $display("FAIL link_count: got %0d want 2", Stall_count); end
    endtask

    task automatic test_priority_zero();
        tick();
        drive_id(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 2'b00);   // older writer of r7
        tick();
        drive_id(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 2'b00);   // younger writer of r7
        tick();
        drive_id(5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 2'b00);
        settle();
        checks++; if (ForwardA !== 2'b01) begin errors++; $display("FAIL prio_fwd_a: got %b want 01", ForwardA); end
        checks++; if (ForwardB !== 2'b01) begin errors++; $display("FAIL prio_fwd_b: got %b want 01", ForwardB); end
        drive_id(5'd7, 1'b0, 5'd7, 1'b0, 1'b0, 5'd0, 2'b00);   // match but not used
        settle();
        checks++; if (ForwardA !== 2'b00) begin errors++; $display("FAIL unused_fwd_a: got %b want 00", ForwardA); end
        drive_id(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 2'b01);   // load into $0
        tick();
        drive_id(5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 2'b00);
        settle();
        checks++; if (ForwardA !== 2'b00) begin errors++; $display("FAIL zero_fwd_a: got %b want 00", ForwardA); end
        checks++; if (ForwardB !== 2'b00) begin errors++; $display("FAIL zero_fwd_b: got %b want 00", ForwardB); end
        checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL zero_stall: got %b want 0", Stall); end
    endtask

    task automatic test_flush_vs_hazard();
        tick(); drive_nop();
        tick();
        drive_id(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 2'b01);   // lw r5
        tick();
        drive_id(5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd6, 2'b00);   // squashed reader
        Branch_Flush = 1'b1;
        settle();
        checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b want 0", Stall); end
        checks++; if (Bubble !== 1'b1) begin errors++; $display("FAIL flush_bubble: got %b want 1", Bubble); end
        tick();
        Branch_Flush = 1'b0;
        drive_id(5'd6, 1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 2'b00);
        settle();
        checks++; if (ForwardA !== 2'b00) begin errors++; $display("FAIL flush_no_ex_fwd: got %b want 00", ForwardA); end
        checks++; if (ForwardB !== 2'b10) begin errors++; $display("FAIL flush_mem_fwd: got %b want 10", ForwardB); end
        checks++; if (Stall_count !== 16'd2) begin errors++; $display("FAIL flush_count: got %0d want 2", Stall_count); end
    endtask

    task automatic test_hold_reset();
        tick(); drive_nop();
        tick();
        drive_id(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 2'b01);   // lw r9
        tick();
        drive_id(5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 2'b00);
        Hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL hold_stall_%0d: got %b want 1", i, Stall); end
            checks++; if (Bubble !== 1'b1) begin errors++; $display("FAIL hold_bubble_%0d: got %b want 1", i, Bubble); end
            checks++; if (Stall_count !== 16'd2) begin errors++; $display("FAIL hold_count_%0d: got %0d want 2", i, Stall_count); end
            tick();
        end
        Hold = 1'b0;
        settle();
        checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL hold_frozen_hazard: got %b want 1", Stall); end
        checks++; if (Stall_count !== 16'd2) begin errors++; $display("FAIL hold_count_after: got %0d want 2", Stall_count); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL rst_mid_stall: got %b want 0", Stall); end
        checks++; if (Bubble !== 1'b0) begin errors++; $display("FAIL rst_bubble: got %b want 0", Bubble); end
        checks++; if (ForwardA !== 2'b00) begin errors++; $display("FAIL rst_fwd_a: got %b want 00", ForwardA); end
        checks++; if (MEM_MemtoReg !== 2'b00) begin errors++; $display("FAIL rst_m2r: got %b want 00", MEM_MemtoReg); end
        checks++; if (Stall_count !== 16'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", Stall_count); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_alu_back_to_back();
        test_load_use();
        test_link();
        test_priority_zero();
        test_flush_vs_hazard();
        test_hold_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
Control-side producer for the ID-stage operand forwarding muxes. It generates ForwardA/ForwardB selects, the MEM-stage write-back source code (MEM_MemtoReg), and the load-use/link stall and bubble controls. It keeps its own shadow copy of the EX and MEM destination fields, advanced in lockstep with the datapath pipeline registers. It sits beside the ID/EX pipeline register; the datapath forwarding muxes consume its outputs.

Parameters:
REG_AW, 5, register-number width
CNT_W, 16, width of saturating stall-cycle counter

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  synchronous, active-high
Hold  in  1  global freeze (memory wait); all state holds
Branch_Flush  in  1  ID instruction squashed (taken branch/jump)
ID_rs  in  REG_AW  source register 1 of ID instruction
ID_rt  in  REG_AW  source register 2 of ID instruction
ID_uses_rs  in  1  ID instruction reads rs
ID_uses_rt  in  1  ID instruction reads rt
ID_RegWrite  in  1  ID instruction writes a register
ID_Write_reg  in  REG_AW  ID destination register
ID_MemtoReg  in  2  ID write-back source: 00 ALU, 01 load data, 10 PC_next
ForwardA  out  2  00 ID_Read_data1, 01 EX_out, 10 MEM source
ForwardB  out  2  same encoding for operand 2
MEM_MemtoReg  out  2  write-back source of the MEM-stage instruction
Stall  out  1  hold PC and IF/ID
Bubble  out  1  load NOP into ID/EX
Stall_count  out  CNT_W  cycles with Stall=1, saturating

Behaviour:
- State: ex_valid, ex_rd, ex_m2r; mem_valid, mem_rd, mem_m2r.
- An entry is a valid producer only if RegWrite=1 and rd!=0. Register $0 is never forwarded and never causes a stall.
- Combinational forward select for each operand src in {rs, rt} with use flag u:
  - u=1, ex_valid, ex_rd==src, ex_m2r==00: select 01.
  - Else u=1, mem_valid, mem_rd==src: select 10.
  - Else: select 00.
  - EX has priority over MEM; the youngest producer wins.
- Hazard: u=1, ex_valid, ex_rd==src, ex_m2r!=00 (load or link) sets Stall=1 and Bubble=1. It lasts exactly 1 cycle, because next cycle the producer is in MEM and forwards via select 10. During the hazard cycle the forward select for that operand is still computed but ignored.
- Branch_Flush=1: Bubble=1 and Stall=0. Flush overrides the hazard; a squashed instruction never stalls.
- MEM_MemtoReg = mem_m2r when mem_valid, else 00.
- Clock edge, when Hold=0:
  - mem <= ex.
  - ex <= bubble (valid=0, rd=0, m2r=00) if Bubble, else {ID_RegWrite && ID_Write_reg!=0, ID_Write_reg, ID_MemtoReg}.
  - Stall_count increments when Stall=1 and saturates at all-ones.
- Hold=1: no state changes. Outputs are recomputed from held state and live inputs; Stall is forced to 1 but is not counted.
- Reset: all valid bits, rd and m2r fields, and Stall_count go to 0. With state cleared, ForwardA=ForwardB=00, MEM_MemtoReg=00, Stall=0, and Bubble=Branch_Flush. Reset dominates Hold. Reset mid-stall clears the pending hazard; no stall occurs on the cycle after reset.
- Latency: forward and stall outputs are combinational from the current cycle; tracking state has one-cycle update latency.

Decomposition:
- Shared package: MemtoReg encodings (M2R_ALU=00, M2R_MEM=01, M2R_PC=10), forward encodings (FWD_REG=00, FWD_EX=01, FWD_MEM=10), REG_AW.
- One natural sub-module, fwd_select: a combinational per-operand compare. It is instantiated twice (rs→A, rt→B) and outputs the select plus a hazard flag.

Test Plan:
1. ALU back-to-back: add r3 in EX (m2r 00), ID reads rs=r3 -> ForwardA=01, Stall=0; next cycle a new ID instruction reads rt=r3 -> ForwardB=10, MEM_MemtoReg=00.
2. Load-use: lw r5 in EX (m2r 01), ID rt=r5 -> Stall=1, Bubble=1 for exactly 1 cycle; next cycle ForwardB=10, MEM_MemtoReg=01; Stall_count=1.
3. Link: jal writes r31 (m2r 10), ID reads rs=r31 -> 1-cycle stall, then ForwardA=10 with MEM_MemtoReg=10.
4. Priority and $0: EX and MEM both write r7, ID reads r7 -> select 01. Producer rd=0 with ID reading r0 -> select 00, no stall.
5. Flush vs hazard: load-use condition with Branch_Flush=1 -> Stall=0, Bubble=1; next cycle ex_valid=0, so no forwarding from EX.
6. Hold and reset: assert Hold 3 cycles during a load-use -> Stall=1 held, Stall_count unchanged, state frozen. Then assert reset -> all outputs 00/0, Stall_count=0.
